// File: rtl/onchip_stream_packer.sv
// -----------------------------------------------------------------------------
// onchip_stream_packer
//
// Avalon-MM write master feeding a 32-bit single-port on-chip RAM. It takes an
// 8-bit ready/valid byte stream with an end-of-record marker, packs the bytes
// little-endian into 32-bit words and writes them to consecutive RAM words
// starting at a programmed address. Word count, completion and overflow are
// reported back to the control/CSR logic.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   start                 one-cycle pulse, accepted only while idle
//   start_addr            first RAM word address of the record (< DEPTH)
//   max_words             word capacity for this record (0 = no room at all)
//   in_data/in_valid/
//   in_last/in_ready      byte stream; a byte moves when in_valid & in_ready
//   mem_*                 Avalon-MM write master towards the RAM (no waitrequest)
//   busy                  high from the cycle after an accepted start until done
//   done                  one-cycle completion pulse
//   overflow              record did not fit in max_words (sticky until start)
//   words_written         RAM words written for the current/last record
// -----------------------------------------------------------------------------
module onchip_stream_packer #(
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 87500
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] max_words,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_written
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;        // word address of the next write
    logic [ADDR_W-1:0] limit_r;       // latched max_words
    logic [ADDR_W-1:0] words_r;       // words written so far
    logic [1:0]        lane_r;        // next byte lane to fill
    logic [31:0]       data_r;        // word being assembled
    logic [3:0]        be_r;          // lanes filled so far
    logic              last_seen_r;   // current word holds the record's last byte
    logic              in_ready_r;
    logic              cs_r;
    logic              wr_r;
    logic              busy_r;
    logic              done_r;
    logic              ovf_r;

    logic              accept_s;

    // RAM address successor; the RAM is not a power of two deep, so wrap by compare.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] n;
        if (a == ADDR_LAST) begin
            n = ADDR_ZERO;
        end else begin
            n = a + ADDR_ONE;
        end
        return n;
    endfunction

    // Drop one byte into lane k of a word, leaving the other lanes untouched.
    function automatic logic [31:0] place_byte(input logic [31:0] w,
                                               input logic [1:0]  k,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r        = w;
        endcase
        return r;
    endfunction

    // One-hot enable for lane k.
    function automatic logic [3:0] lane_bit(input logic [1:0] k);
        logic [3:0] m;
        case (k)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0010;
            2'd2:    m = 4'b0100;
            2'd3:    m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // in_ready is registered, so a byte moves exactly when the registered
    // ready and the upstream valid coincide.
    assign accept_s = in_valid & in_ready_r;

    // The RAM clock is never gated by this block.
    assign mem_clken = 1'b1;

    assign in_ready       = in_ready_r;
    assign mem_address    = addr_r;
    assign mem_byteenable = be_r;
    assign mem_chipselect = cs_r;
    assign mem_write      = wr_r;
    assign mem_writedata  = data_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign overflow       = ovf_r;
    assign words_written  = words_r;

    // Record sequencer: state, datapath and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= ADDR_ZERO;
            limit_r     <= ADDR_ZERO;
            words_r     <= ADDR_ZERO;
            lane_r      <= 2'd0;
            data_r      <= 32'h0000_0000;
            be_r        <= 4'b0000;
            last_seen_r <= 1'b0;
            in_ready_r  <= 1'b0;
            cs_r        <= 1'b0;
            wr_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless re-armed below
            done_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    cs_r <= 1'b0;
                    wr_r <= 1'b0;
                    if (start) begin
                        addr_r      <= start_addr;
                        limit_r     <= max_words;
                        words_r     <= ADDR_ZERO;
                        lane_r      <= 2'd0;
                        data_r      <= 32'h0000_0000;
                        be_r        <= 4'b0000;
                        last_seen_r <= 1'b0;
                        busy_r      <= 1'b1;
                        in_ready_r  <= 1'b1;
                        // No room at all: swallow the record without writing.
                        if (max_words == ADDR_ZERO) begin
                            state_r <= ST_DRAIN;
                            ovf_r   <= 1'b1;
                        end else begin
                            state_r <= ST_FILL;
                            ovf_r   <= 1'b0;
                        end
                    end else begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end

                ST_FILL: begin
                    if (accept_s) begin
                        data_r <= place_byte(data_r, lane_r, in_data);
                        be_r   <= be_r | lane_bit(lane_r);
                        lane_r <= lane_r + 2'd1;
                        // Word full or record ended: strobe it next cycle and
                        // hold the stream off while the write happens.
                        if ((lane_r == 2'd3) || in_last) begin
                            state_r     <= ST_WRITE;
                            last_seen_r <= in_last;
                            cs_r        <= 1'b1;
                            wr_r        <= 1'b1;
                            in_ready_r  <= 1'b0;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else begin
                        state_r <= ST_FILL;
                    end
                end

                ST_WRITE: begin
                    // The RAM has no waitrequest: the write lands this cycle.
                    cs_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    addr_r  <= next_addr(addr_r);
                    words_r <= words_r + ADDR_ONE;
                    lane_r  <= 2'd0;
                    data_r  <= 32'h0000_0000;
                    be_r    <= 4'b0000;
                    if (last_seen_r) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        in_ready_r <= 1'b0;
                    end else if ((words_r + ADDR_ONE) == limit_r) begin
                        // Capacity used up but the record goes on: discard the rest.
                        state_r    <= ST_DRAIN;
                        ovf_r      <= 1'b1;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r    <= ST_FILL;
                        in_ready_r <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (accept_s && in_last) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        in_ready_r <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here.
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b0;
                end

                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    cs_r       <= 1'b0;
                    wr_r       <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
